// File: rtl/dvbc_srrc_rx.sv
// Receive-side SRRC matched filter for DVB-C: 2 samples/symbol in, one I/Q symbol out per pair.
// Time-multiplexed MAC (one multiplier per rail, one tap per cycle) with run-time loadable taps.
module dvbc_srrc_rx #(
  parameter int DATA_W = 10,
  parameter int COEF_W = 12,
  parameter int OUT_W  = 10,
  parameter int NTAPS  = 33,
  parameter int SHIFT  = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sync,
  input  logic [DATA_W-1:0]          in_i,
  input  logic [DATA_W-1:0]          in_q,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]          coef_data,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_i,
  output logic [OUT_W-1:0]           out_q
);

  localparam int AW    = $clog2(NTAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + AW;

  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(2**(SHIFT-1));
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] MINV = -((ACC_W+1)'(2**(OUT_W-1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      phase_q, phase_d;
  logic [AW-1:0]             k_q;
  logic signed [DATA_W-1:0]  di_q [NTAPS];
  logic signed [DATA_W-1:0]  dq_q [NTAPS];
  logic signed [COEF_W-1:0]  coef_q [NTAPS];
  logic signed [ACC_W-1:0]   acc_i_q, acc_q_q;
  logic signed [ACC_W-1:0]   sum_i, sum_q;
  logic signed [PW-1:0]      prod_i, prod_q;
  logic [OUT_W-1:0]          out_i_q, out_q_q;
  logic                      accept, pair_done, coef_wr, last_tap;

  // Round half toward +inf, then clamp to the signed output range.
  function automatic logic [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] r;
    r = ($signed({a[ACC_W-1], a}) + RND) >>> SHIFT;
    if (r > MAXV) return MAXV[OUT_W-1:0];
    if (r < MINV) return MINV[OUT_W-1:0];
    return r[OUT_W-1:0];
  endfunction

  always_comb begin
    // OUT also accepts, so a continuous stream loses only the NTAPS MAC cycles per symbol.
    in_ready  = (state_q == IDLE) || (state_q == OUT);
    accept    = in_valid && in_ready;
    pair_done = accept && !in_sync && phase_q;
    coef_wr   = coef_we && (state_q == IDLE) && (32'(coef_addr) < NTAPS);
    last_tap  = (k_q == AW'(NTAPS-1));

    phase_d = phase_q;
    if (accept) phase_d = in_sync ? 1'b1 : ~phase_q;

    state_d = state_q;
    unique case (state_q)
      IDLE, OUT: state_d = pair_done ? MAC : IDLE;
      MAC:       if (last_tap) state_d = OUT;
      default:   state_d = IDLE;
    endcase

    prod_i = PW'(di_q[k_q]) * PW'(coef_q[k_q]);
    prod_q = PW'(dq_q[k_q]) * PW'(coef_q[k_q]);
    sum_i  = acc_i_q + ACC_W'(prod_i);
    sum_q  = acc_q_q + ACC_W'(prod_q);

    out_valid = (state_q == OUT);
    out_i     = out_i_q;
    out_q     = out_q_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      k_q     <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      out_i_q <= '0;
      out_q_q <= '0;
      for (int unsigned j = 0; j < NTAPS; j++) begin
        di_q[j]   <= '0;
        dq_q[j]   <= '0;
        coef_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;

      if (accept) begin
        di_q[0] <= in_i;
        dq_q[0] <= in_q;
        for (int unsigned j = 1; j < NTAPS; j++) begin
          di_q[j] <= di_q[j-1];
          dq_q[j] <= dq_q[j-1];
        end
      end

      if (coef_wr) coef_q[coef_addr] <= coef_data;

      if (state_q == MAC) begin
        if (last_tap) begin
          out_i_q <= round_sat(sum_i);
          out_q_q <= round_sat(sum_q);
          acc_i_q <= '0;
          acc_q_q <= '0;
          k_q     <= '0;
        end else begin
          acc_i_q <= sum_i;
          acc_q_q <= sum_q;
          k_q     <= k_q + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dvbc_srrc_rx.sv
// Self-checking bench for dvbc_srrc_rx: directed plan steps plus randomized traffic vs. an arithmetic model.
module tb_dvbc_srrc_rx;

  localparam int DATA_W = 10;
  localparam int COEF_W = 12;
  localparam int OUT_W  = 10;
  localparam int NTAPS  = 33;
  localparam int SHIFT  = 11;
  localparam int AW     = $clog2(NTAPS);

  logic              clk = 1'b0;
  logic              rst, in_valid, in_sync, coef_we;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] in_i, in_q;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic [OUT_W-1:0]  out_i, out_q;

  int n_assert = 0;
  int n_fail   = 0;

  longint mdi [NTAPS];
  longint mdq [NTAPS];
  longint mc  [NTAPS];
  bit     mphase;
  bit     got_out;
  longint last_i, last_q;

  always #5 clk = ~clk;

  dvbc_srrc_rx #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .NTAPS(NTAPS), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sync(in_sync),
    .in_i(in_i), .in_q(in_q),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_i(out_i), .out_q(out_q)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NTAPS; k++) begin
      mdi[k] = 0; mdq[k] = 0; mc[k] = 0;
    end
    mphase = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  function automatic longint to_coef(input longint d);
    logic signed [COEF_W-1:0] t;
    t = COEF_W'(d);
    return longint'(t);
  endfunction

  function automatic longint to_samp(input longint d);
    logic signed [DATA_W-1:0] t;
    t = DATA_W'(d);
    return longint'(t);
  endfunction

  // Reference: exact dot product, then floor((s + 2^(SHIFT-1)) / 2^SHIFT), then clip.
  function automatic longint fir(input bit rail_q);
    longint s, r, lim;
    s = 0;
    for (int k = 0; k < NTAPS; k++) s += (rail_q ? mdq[k] : mdi[k]) * mc[k];
    r   = (s + (longint'(1) << (SHIFT-1))) >>> SHIFT;
    lim = longint'(1) << (OUT_W-1);
    if (r > lim - 1) r = lim - 1;
    if (r < -lim)    r = -lim;
    return r;
  endfunction

  task automatic wcoef(input int a, input longint d);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = COEF_W'(d);
    tick();
    coef_we = 1'b0;
    if (a < NTAPS) mc[a] = to_coef(d);
  endtask

  task automatic send(input longint i, input longint q, input bit sync, input bit we,
                      input int a, input longint d, output bit done);
    int w = 0;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) chk("ready_timeout", w, 0);
    in_valid  = 1'b1;
    in_i      = DATA_W'(i);
    in_q      = DATA_W'(q);
    in_sync   = sync;
    coef_we   = we;
    coef_addr = AW'(a);
    coef_data = COEF_W'(d);
    tick();
    in_valid = 1'b0;
    in_sync  = 1'b0;
    coef_we  = 1'b0;
    for (int k = NTAPS-1; k > 0; k--) begin
      mdi[k] = mdi[k-1];
      mdq[k] = mdq[k-1];
    end
    mdi[0] = to_samp(i);
    mdq[0] = to_samp(q);
    done   = !sync && mphase;
    mphase = sync ? 1'b1 : !mphase;
    if (we && a < NTAPS) mc[a] = to_coef(d);
  endtask

  // Waits for the symbol started by the last pair; 'spent' = cycles already ticked since the accept.
  task automatic check_out(input string tag, input int spent);
    int n;
    longint ei, eq;
    n  = spent;
    ei = fir(1'b0);
    eq = fir(1'b1);
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, NTAPS);
    chk({tag, "_rdy"}, in_ready, 1);
    last_i = longint'($signed(out_i));
    last_q = longint'($signed(out_q));
    chk({tag, "_i"}, last_i, ei);
    chk({tag, "_q"}, last_q, eq);
    tick();
    chk({tag, "_pulse"}, out_valid, 0);
  endtask

  task automatic feed(input string tag, input longint i, input longint q, input bit sync = 1'b0,
                      input bit we = 1'b0, input int a = 0, input longint d = 0);
    bit done;
    send(i, q, sync, we, a, d, done);
    got_out = done;
    if (done) check_out(tag, 0);
  endtask

  initial begin
    bit     done, seen;
    int     gap;
    longint ri, rq;

    rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0; coef_we = 1'b0;
    in_i = '0; in_q = '0; coef_addr = '0; coef_data = '0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();

    // Reset state
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_out_i", $signed(out_i), 0);
    chk("rst_out_q", $signed(out_q), 0);

    // 1. Scaling and rounding
    wcoef(0, 1024);
    feed("t1a", 100, -7);
    chk("t1_nout", got_out, 0);
    feed("t1b", 200, -7);
    chk("t1_got", got_out, 1);
    chk("t1_i_const", last_i, 100);
    chk("t1_q_const", last_q, -3);

    // 2. Impulse response
    do_reset();
    for (int k = 0; k < NTAPS; k++) wcoef(k, 64 * k);
    for (int n = 1; n <= 16; n++) begin
      feed("t2", (n == 1) ? 256 : 0, 0);
      feed("t2", 0, 0);
      chk("t2_i_const", last_i, 8 * (2 * n - 1));
      chk("t2_q_const", last_q, 0);
    end

    // 3. Saturation
    do_reset();
    for (int k = 0; k < NTAPS; k++) wcoef(k, 2047);
    for (int n = 0; n < 20; n++) begin
      feed("t3", 511, -512);
      feed("t3", 511, -512);
      chk("t3_i_const", last_i, 511);
      chk("t3_q_const", last_q, -512);
    end

    // 4. Handshake timing with in_valid held high
    do_reset();
    in_valid = 1'b1;
    for (int c = 0; c < 71; c++) begin
      chk("t4_ready", in_ready, ((c % 35) < 2) ? 1 : 0);
      chk("t4_valid", out_valid, ((c % 35) == 0 && c > 0) ? 1 : 0);
      tick();
    end
    in_valid = 1'b0;

    // 5. Sync realignment
    do_reset();
    wcoef(0, 1024);
    wcoef(1, 512);
    wcoef(2, 256);
    feed("t5a", 40, 0);
    feed("t5b", 80, 0, 1'b1);
    chk("t5_b_nout", got_out, 0);
    seen = 1'b0;
    for (int c = 0; c < NTAPS + 3; c++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("t5_quiet", seen, 0);
    feed("t5c", 120, 0);
    chk("t5_got", got_out, 1);
    chk("t5_i_const", last_i, 85);

    // 6. Busy coefficient write, then reset mid-MAC
    do_reset();
    wcoef(0, 1024);
    feed("t6a", 10, 0);
    send(300, -50, 1'b0, 1'b0, 0, 0, done);
    chk("t6_done", done, 1);
    for (int c = 0; c < 3; c++) begin
      coef_we = 1'b1; coef_addr = '0; coef_data = COEF_W'(-500);
      tick();
    end
    coef_we = 1'b0;
    check_out("t6b", 3);
    chk("t6_i_const", last_i, 150);
    chk("t6_q_const", last_q, -25);
    feed("t6c", 0, 0);
    feed("t6d", 64, 64);
    chk("t6_rb_i", last_i, 32);
    chk("t6_rb_q", last_q, 32);
    feed("t6e", 7, 7);
    send(100, 100, 1'b0, 1'b0, 0, 0, done);
    for (int c = 0; c < 5; c++) tick();
    do_reset();
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_i", $signed(out_i), 0);
    chk("t6_rst_q", $signed(out_q), 0);
    seen = 1'b0;
    for (int c = 0; c < NTAPS + 5; c++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("t6_no_out", seen, 0);

    // Randomized taps, samples, syncs and coefficient writes (some out of range)
    do_reset();
    for (int k = 0; k < NTAPS; k++) wcoef(k, int'($urandom_range(0, 4095)) - 2048);
    wcoef(NTAPS + int'($urandom_range(0, 30)), 1234);
    for (int s = 0; s < 120; s++) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
      ri = int'($urandom_range(0, 1023)) - 512;
      rq = int'($urandom_range(0, 1023)) - 512;
      feed("rnd", ri, rq, ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 4) == 0), int'($urandom_range(0, 40)),
           int'($urandom_range(0, 4095)) - 2048);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
